// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared states, field widths and length check for the instruction-memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam int LEN_WIDTH      = 16;
    localparam int BYTES_PER_WORD = 4;

    // A load must carry at least one word and must fit in the memory.
    function automatic logic length_ok(input logic [LEN_WIDTH-1:0] n, input int unsigned depth);
        return (n != '0) && (32'(n) <= depth);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte receive stream and instruction-memory write port of the loader
interface imem_loader_if;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs four big-endian bytes into one 32-bit word
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [23:0] shift;
    logic [1:0]  count;

    // The last byte completes the word combinationally, so only three need storing.
    assign word_ready = byte_valid && (count == 2'(BYTES_PER_WORD - 1));
    assign word       = {shift, byte_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift <= '0;
            count <= '0;
        end else if (clear) begin
            shift <= '0;
            count <= '0;
        end else if (byte_valid) begin
            shift <= {shift[15:0], byte_data};
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed byte stream into instruction memory while holding the CPU
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 1000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam int unsigned DEPTH  = 32'd1 << ADDR_WIDTH;
    localparam int          IDLE_W = $clog2(TIMEOUT + 1);

    state_t                state;
    state_t                next_state;
    logic [7:0]            len_hi;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH-1:0]  word_cnt;
    logic [IDLE_W-1:0]     idle_cnt;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           word;
    logic                  word_ready;
    logic                  waiting;
    logic                  expired;
    logic                  start_ok;

    assign waiting  = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
    assign expired  = waiting && !bus.rx_valid && (idle_cnt == IDLE_W'(TIMEOUT - 1));
    assign start_ok = start && ((state == IDLE) || (state == DONE) || (state == ERR));

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .byte_valid (bus.rx_valid && (state == DATA)),
        .byte_data  (bus.rx_data),
        .word       (word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) next_state = LEN_HI;
            end
            LEN_HI: begin
                if (bus.rx_valid)  next_state = LEN_LO;
                else if (expired)  next_state = ERR;
            end
            LEN_LO: begin
                if (bus.rx_valid) begin
                    next_state = length_ok({len_hi, bus.rx_data}, DEPTH) ? DATA : ERR;
                end else if (expired) begin
                    next_state = ERR;
                end
            end
            DATA: begin
                if (word_ready)    next_state = WRITE;
                else if (expired)  next_state = ERR;
            end
            WRITE: begin
                next_state = (word_cnt + 1'b1 == len) ? DONE : DATA;
            end
            default: next_state = IDLE;
        endcase
    end

    // Address and data are captured only when a full word lands, so they stay quiet otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_hi   <= '0;
            len      <= '0;
            word_cnt <= '0;
            idle_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            idle_cnt <= (waiting && !bus.rx_valid) ? idle_cnt + 1'b1 : '0;
            if (state == LEN_HI && bus.rx_valid) len_hi <= bus.rx_data;
            if (state == LEN_LO && bus.rx_valid) len    <= {len_hi, bus.rx_data};
            if (start_ok) begin
                word_cnt <= '0;
            end else if (state == WRITE) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (word_ready) begin
                addr_q  <= {{(30 - LEN_WIDTH){1'b0}}, word_cnt, 2'b00};
                wdata_q <= word;
            end
        end
    end

    assign bus.mem_we    = (state == WRITE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign busy     = (state == LEN_HI) || (state == LEN_LO) || (state == DATA) || (state == WRITE);
    assign cpu_hold = busy || (state == ERR);
    assign done     = (state == DONE);
    assign error    = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader with a write scoreboard
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic cpu_hold, busy, done, error;

    imem_loader_if bus ();

    imem_loader #(
        .ADDR_WIDTH (8),
        .TIMEOUT    (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          nwrites = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_item;
    int          base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_status(input string name, input logic h, input logic b, input logic d, input logic e);
        chk({name, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
        chk({name, "_busy"},     32'(busy),     32'(b));
        chk({name, "_done"},     32'(done),     32'(d));
        chk({name, "_error"},    32'(error),    32'(e));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_len(input logic [15:0] n);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
    endtask

    // Word k must land at byte address 4*k; the trailing cycle is the WRITE gap.
    task automatic send_word(input logic [31:0] w, input int k, input logic junk);
        exp_q.push_back({32'(k * 4), w});
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
        if (junk) send_byte(8'h77);
        else      tick();
    endtask

    function automatic logic [31:0] pat(input int k);
        return {8'(k), 8'(~k), 8'hA5, 8'(k ^ 8'h3C)};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%0h required=no_write", bus.mem_addr);
                end else begin
                    exp_item = exp_q.pop_front();
                    chk("write_addr", bus.mem_addr,  exp_item[63:32]);
                    chk("write_data", bus.mem_wdata, exp_item[31:0]);
                end
                nwrites++;
                last_addr = bus.mem_addr;
            end else begin
                chk("stable_addr",  bus.mem_addr,  prev_addr);
                chk("stable_wdata", bus.mem_wdata, prev_wdata);
            end
        end
        prev_addr  = bus.mem_addr;
        prev_wdata = bus.mem_wdata;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        repeat (3) tick();
        chk_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_we",    32'(bus.mem_we), 32'd0);
        chk("reset_addr",  bus.mem_addr,    32'd0);
        chk("reset_wdata", bus.mem_wdata,   32'd0);
        reset = 1'b0;
        tick();

        // Bytes while idle must not move the FSM.
        repeat (3) send_byte(8'h55);
        chk_status("idle_rx", 1'b0, 1'b0, 1'b0, 1'b0);

        // Basic two-word load with literal expectations.
        pulse_start();
        chk_status("len_hi", 1'b1, 1'b1, 1'b0, 1'b0);
        send_byte(8'h00);
        send_byte(8'h02);
        exp_q.push_back({32'h0, 32'h20040004});
        send_byte(8'h20); send_byte(8'h04); send_byte(8'h00); send_byte(8'h04);
        chk("basic_we0",    32'(bus.mem_we), 32'd1);
        chk("basic_addr0",  bus.mem_addr,    32'h0);
        chk("basic_wdata0", bus.mem_wdata,   32'h20040004);
        chk_status("basic_write", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        exp_q.push_back({32'h4, 32'h0C000003});
        send_byte(8'h0C); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
        chk("basic_addr1",  bus.mem_addr,  32'h4);
        chk("basic_wdata1", bus.mem_wdata, 32'h0C000003);
        tick();
        chk_status("basic_done", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("basic_nwrites", 32'(nwrites), 32'd2);

        // Length errors.
        pulse_start();
        send_len(16'd0);
        chk_status("len_zero", 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        chk_status("len_zero_held", 1'b1, 1'b0, 1'b0, 1'b1);
        pulse_start();
        send_len(16'd257);
        chk_status("len_257", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("len_no_write", 32'(nwrites), 32'd2);

        // Timeout after two data bytes of a three-word load.
        pulse_start();
        send_len(16'd3);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (15) tick();
        chk_status("timeout_15", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_status("timeout_16", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("timeout_no_write", 32'(nwrites), 32'd2);

        // The partial word must not leak into the next load.
        pulse_start();
        send_len(16'd1);
        send_word(32'hCAFEF00D, 0, 1'b0);
        chk_status("after_timeout_done", 1'b0, 1'b0, 1'b1, 1'b0);

        // Start during DATA and a byte during WRITE are both ignored.
        pulse_start();
        send_len(16'd2);
        exp_q.push_back({32'h0, 32'hDEADBEEF});
        send_byte(8'hDE);
        send_byte(8'hAD);
        pulse_start();
        chk_status("start_in_data", 1'b1, 1'b1, 1'b0, 1'b0);
        send_byte(8'hBE);
        send_byte(8'hEF);
        send_byte(8'h77);
        send_word(32'h01234567, 1, 1'b0);
        chk_status("ignored_done", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ignored_last_addr", last_addr, 32'h4);

        // Reset after the third word of a five-word load.
        pulse_start();
        send_len(16'd5);
        for (int k = 0; k < 3; k++) send_word(pat(k), k, 1'b0);
        reset = 1'b1;
        #1;
        chk_status("midreset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midreset_we",    32'(bus.mem_we), 32'd0);
        chk("midreset_addr",  bus.mem_addr,    32'd0);
        chk("midreset_wdata", bus.mem_wdata,   32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("midreset_pending", 32'(exp_q.size()), 32'd0);
        pulse_start();
        send_len(16'd2);
        send_word(32'hA1B2C3D4, 0, 1'b0);
        send_word(32'h0F1E2D3C, 1, 1'b0);
        chk_status("reload_done", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("reload_last_addr", last_addr, 32'h4);

        // Full-depth back-to-back load.
        base = nwrites;
        pulse_start();
        send_len(16'd256);
        for (int k = 0; k < 256; k++) send_word(pat(k), k, 1'b0);
        chk_status("full_done", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("full_last_addr", last_addr, 32'h3FC);
        chk("full_nwrites", 32'(nwrites - base), 32'd256);
        chk("final_pending", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
